// File: rtl/sobel_mac_seq_if.sv
// Bundle of the window-in / MAC / result-out signals of the Sobel sequencer.
// The slave view is the sequencer; the master view is its environment.
interface sobel_mac_seq_if;
    logic               valid_i;
    logic               ready_o;
    logic [71:0]        window_i;
    logic [15:0]        mac_a_o;
    logic [15:0]        mac_b_o;
    logic               mac_ce_o;
    logic               mac_first_o;
    logic [31:0]        mac_acc_i;
    logic               valid_o;
    logic               ready_i;
    logic signed [10:0] gx_o;
    logic signed [10:0] gy_o;
    logic [7:0]         mag_o;

    modport slave (
        input  valid_i, window_i, mac_acc_i, ready_i,
        output ready_o, mac_a_o, mac_b_o, mac_ce_o, mac_first_o,
               valid_o, gx_o, gy_o, mag_o
    );

    modport master (
        output valid_i, window_i, mac_acc_i, ready_i,
        input  ready_o, mac_a_o, mac_b_o, mac_ce_o, mac_first_o,
               valid_o, gx_o, gy_o, mag_o
    );
endinterface

// File: rtl/sobel_mac_seq.sv
// Sobel gradient sequencer: streams the 12 Gx/Gy terms of a 3x3 window into an
// external MAC, one per cycle, then captures the sums and forms |gx|+|gy|.
module sobel_mac_seq #(
    parameter int MAC_LAT = 1
) (
    input logic            clk_i,
    input logic            rst_ni,
    sobel_mac_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, GX, GY, DRAIN, OUT} state_t;

    localparam logic [4:0] GX_LAST = 5'd6;
    localparam logic [4:0] GY_LAST = 5'd12;
    localparam logic [4:0] GX_CAP  = 5'(6 + MAC_LAT);
    localparam logic [4:0] GY_CAP  = 5'(12 + MAC_LAT);

    state_t             state_reg, state_next;
    logic [4:0]         cnt_reg;
    logic               rdy_en_reg;
    logic [71:0]        win_reg;
    logic signed [10:0] gx_reg, gy_reg;
    logic [7:0]         mag_reg;

    logic [7:0]         pix [9];
    logic               busy, accept;
    logic [3:0]         term_k;
    logic [3:0]         pix_sel;
    logic signed [2:0]  coef;
    logic [10:0]        acc_low;
    logic [11:0]        gx_ext, gy_ext, abs_gx, abs_gy, mag_sum;
    logic [7:0]         mag_next;
    logic               acc_unused;

    logic               ready_c, ce_c, first_c, valid_c;
    logic [15:0]        a_c, b_c;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pix
            assign pix[gi] = win_reg[8*gi +: 8];
        end
    endgenerate

    assign busy       = (state_reg == GX) || (state_reg == GY) || (state_reg == DRAIN);
    assign accept     = bus.valid_i && ready_c;
    assign term_k     = 4'(cnt_reg - 5'd1);
    assign acc_low    = bus.mac_acc_i[10:0];
    assign acc_unused = ^bus.mac_acc_i[31:11];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)                state_next = GX;
            GX:      if (cnt_reg == GX_LAST)    state_next = GY;
            GY:      if (cnt_reg == GY_LAST)    state_next = DRAIN;
            DRAIN:   if (cnt_reg == GY_CAP)     state_next = OUT;
            OUT:     if (bus.ready_i)           state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Term schedule: k = 0..5 builds Gx, k = 6..11 builds Gy.
    always_comb begin
        pix_sel = 4'd0;
        coef    = 3'sd0;
        case (term_k)
            4'd0:  begin pix_sel = 4'd0; coef = -3'sd1; end
            4'd1:  begin pix_sel = 4'd2; coef =  3'sd1; end
            4'd2:  begin pix_sel = 4'd3; coef = -3'sd2; end
            4'd3:  begin pix_sel = 4'd5; coef =  3'sd2; end
            4'd4:  begin pix_sel = 4'd6; coef = -3'sd1; end
            4'd5:  begin pix_sel = 4'd8; coef =  3'sd1; end
            4'd6:  begin pix_sel = 4'd0; coef = -3'sd1; end
            4'd7:  begin pix_sel = 4'd1; coef = -3'sd2; end
            4'd8:  begin pix_sel = 4'd2; coef = -3'sd1; end
            4'd9:  begin pix_sel = 4'd6; coef =  3'sd1; end
            4'd10: begin pix_sel = 4'd7; coef =  3'sd2; end
            4'd11: begin pix_sel = 4'd8; coef =  3'sd1; end
            default: begin pix_sel = 4'd0; coef = 3'sd0; end
        endcase
    end

    always_comb begin
        ready_c = (state_reg == IDLE) && rdy_en_reg;
        ce_c    = busy;
        valid_c = (state_reg == OUT);
        first_c = 1'b0;
        a_c     = 16'd0;
        b_c     = 16'd0;
        if ((state_reg == GX) || (state_reg == GY)) begin
            a_c     = {8'd0, pix[pix_sel]};
            b_c     = {{13{coef[2]}}, coef};
            first_c = (term_k == 4'd0) || (term_k == 4'd6);
        end
    end

    // Magnitude uses the gx already held and the gy arriving this cycle.
    assign gx_ext   = {gx_reg[10], gx_reg};
    assign gy_ext   = {acc_low[10], acc_low};
    assign abs_gx   = gx_ext[11] ? (~gx_ext + 12'd1) : gx_ext;
    assign abs_gy   = gy_ext[11] ? (~gy_ext + 12'd1) : gy_ext;
    assign mag_sum  = abs_gx + abs_gy;
    assign mag_next = (mag_sum > 12'd255) ? 8'hFF : mag_sum[7:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg    <= 5'd0;
            rdy_en_reg <= 1'b0;
            win_reg    <= 72'd0;
            gx_reg     <= 11'sd0;
            gy_reg     <= 11'sd0;
            mag_reg    <= 8'd0;
        end else begin
            rdy_en_reg <= 1'b1;
            if (accept) begin
                win_reg <= bus.window_i;
                cnt_reg <= 5'd1;
            end else if (busy) begin
                cnt_reg <= cnt_reg + 5'd1;
            end
            if (busy && (cnt_reg == GX_CAP)) begin
                gx_reg <= acc_low;
            end
            if ((state_reg == DRAIN) && (cnt_reg == GY_CAP)) begin
                gy_reg  <= acc_low;
                mag_reg <= mag_next;
            end
        end
    end

    assign bus.ready_o     = ready_c;
    assign bus.mac_a_o     = a_c;
    assign bus.mac_b_o     = b_c;
    assign bus.mac_ce_o    = ce_c;
    assign bus.mac_first_o = first_c;
    assign bus.valid_o     = valid_c;
    assign bus.gx_o        = gx_reg;
    assign bus.gy_o        = gy_reg;
    assign bus.mag_o       = mag_reg;
endmodule

// File: tb/tb_sobel_mac_seq.sv
// Directed bench for sobel_mac_seq: two instances (MAC_LAT 1 and 4), each with
// an external pipelined MAC model, exercised one at a time by the same suite.
module tb_sobel_mac_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid, ready_in, sel;
    logic [71:0] window;
    int          cur_lat;
    int          n_cmp, n_err;
    logic [15:0] last_a [12];
    logic [15:0] last_b [12];

    sobel_mac_seq_if bus [2] ();

    assign bus[0].valid_i  = valid & ~sel;
    assign bus[1].valid_i  = valid & sel;
    assign bus[0].ready_i  = ready_in & ~sel;
    assign bus[1].ready_i  = ready_in & sel;
    assign bus[0].window_i = window;
    assign bus[1].window_i = window;

    logic               o_ready, o_ce, o_first, o_valid;
    logic [15:0]        o_a, o_b;
    logic signed [10:0] o_gx, o_gy;
    logic [7:0]         o_mag;

    assign o_ready = sel ? bus[1].ready_o     : bus[0].ready_o;
    assign o_ce    = sel ? bus[1].mac_ce_o    : bus[0].mac_ce_o;
    assign o_first = sel ? bus[1].mac_first_o : bus[0].mac_first_o;
    assign o_valid = sel ? bus[1].valid_o     : bus[0].valid_o;
    assign o_a     = sel ? bus[1].mac_a_o     : bus[0].mac_a_o;
    assign o_b     = sel ? bus[1].mac_b_o     : bus[0].mac_b_o;
    assign o_gx    = sel ? bus[1].gx_o        : bus[0].gx_o;
    assign o_gy    = sel ? bus[1].gy_o        : bus[0].gy_o;
    assign o_mag   = sel ? bus[1].mag_o       : bus[0].mag_o;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            localparam int LAT = (gi == 0) ? 1 : 4;
            localparam int TAP = (LAT >= 2) ? LAT - 2 : 0;
            logic signed [31:0] prod, term_d, acc;
            logic signed [31:0] sd [4];
            logic               sf [4];
            logic               term_f;

            sobel_mac_seq #(.MAC_LAT(LAT)) u_dut (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .bus    (bus[gi])
            );

            // MAC model: term in cycle c shows up in the accumulator in cycle c+LAT.
            assign prod   = $signed({16'd0, bus[gi].mac_a_o}) * $signed(bus[gi].mac_b_o);
            assign term_d = (LAT == 1) ? prod : sd[TAP];
            assign term_f = (LAT == 1) ? bus[gi].mac_first_o : sf[TAP];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 4; i++) begin
                        sd[i] <= 32'sd0;
                        sf[i] <= 1'b0;
                    end
                    acc <= 32'sd0;
                end else if (bus[gi].mac_ce_o) begin
                    sd[0] <= prod;
                    sf[0] <= bus[gi].mac_first_o;
                    for (int i = 1; i < 4; i++) begin
                        sd[i] <= sd[i-1];
                        sf[i] <= sf[i-1];
                    end
                    acc <= term_f ? term_d : acc + term_d;
                end
            end
            assign bus[gi].mac_acc_i = acc;
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL lat=%0d %s: got %0h, expected %0h", cur_lat, tag, obs, exp);
        end
    endtask

    task automatic run_window(input logic [71:0] w, input int egx, input int egy, input int emag,
                              input int stall, input bit b2b, input string tag);
        int                 waited;
        bit                 ctl_bad, hold_bad;
        logic [11:0]        firsts;
        logic signed [10:0] gx_s, gy_s;
        logic [7:0]         mag_s;
        valid    = 1'b1;
        window   = w;
        ready_in = 1'b0;
        if (b2b) check_val({tag, "_ready_b2b"}, 32'(o_ready), 32'd1);
        waited = 0;
        while (!o_ready && waited < 50) begin
            step();
            waited++;
        end
        check_val({tag, "_ready"}, 32'(o_ready), 32'd1);
        step();
        window  = ~w;
        firsts  = '0;
        ctl_bad = 1'b0;
        for (int c = 1; c <= 12 + cur_lat; c++) begin
            if (c <= 12) begin
                firsts[c-1] = o_first;
                last_a[c-1] = o_a;
                last_b[c-1] = o_b;
            end else if (o_first || o_a != 16'd0 || o_b != 16'd0) begin
                ctl_bad = 1'b1;
            end
            if (!o_ce || o_valid || o_ready) ctl_bad = 1'b1;
            step();
        end
        check_val({tag, "_ctl"},   32'(ctl_bad), 32'd0);
        check_val({tag, "_first"}, 32'(firsts),  32'h041);
        check_val({tag, "_valid"}, 32'(o_valid), 32'd1);
        check_val({tag, "_gx"},    32'(o_gx),    32'(egx));
        check_val({tag, "_gy"},    32'(o_gy),    32'(egy));
        check_val({tag, "_mag"},   32'(o_mag),   32'(emag));
        gx_s     = o_gx;
        gy_s     = o_gy;
        mag_s    = o_mag;
        hold_bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            step();
            if (!o_valid || o_ready || o_gx !== gx_s || o_gy !== gy_s || o_mag !== mag_s) hold_bad = 1'b1;
        end
        if (stall > 0) check_val({tag, "_hold"}, 32'(hold_bad), 32'd0);
        ready_in = 1'b1;
        check_val({tag, "_ready_in_out"}, 32'(o_ready), 32'd0);
        step();
        ready_in = 1'b0;
        valid    = 1'b0;
        check_val({tag, "_done"},     32'(o_valid), 32'd0);
        check_val({tag, "_idle_rdy"}, 32'(o_ready), 32'd1);
        $display("lat=%0d %-12s gx=%0d gy=%0d mag=%0d stall=%0d", cur_lat, tag, gx_s, gy_s, mag_s, stall);
    endtask

    task automatic run_suite();
        bit stray;
        run_window({9{8'h80}}, 0, 0, 0, 0, 1'b0, "flat");
        run_window({8'hFF, 16'h0, 8'hFF, 16'h0, 8'hFF, 16'h0}, 1020, 0, 255, 0, 1'b0, "vedge");
        run_window({48'h0, 24'hFFFFFF}, 0, -1020, 255, 5, 1'b0, "hedge_bp");
        run_window({8'd10, 64'h0}, 10, 10, 20, 0, 1'b1, "corner_b2b");
        check_val("corner_t0_a", 32'(last_a[0]), 32'd0);
        check_val("corner_t0_b", 32'(last_b[0]), 32'h0000FFFF);
        check_val("corner_t3_b", 32'(last_b[3]), 32'h00000002);
        check_val("corner_t5_a", 32'(last_a[5]), 32'd10);
        check_val("corner_t7_b", 32'(last_b[7]), 32'h0000FFFE);
        check_val("corner_t11_a", 32'(last_a[11]), 32'd10);
        run_window(72'h3, -3, -3, 6, 0, 1'b0, "neg_p0");

        // Abandon a window mid-GY with an asynchronous reset pulse.
        valid  = 1'b1;
        window = {9{8'h80}};
        check_val("rst_pre_ready", 32'(o_ready), 32'd1);
        step();
        valid = 1'b0;
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_valid", 32'(o_valid), 32'd0);
        check_val("rst_a",     32'(o_a),     32'd0);
        check_val("rst_b",     32'(o_b),     32'd0);
        check_val("rst_ce",    32'(o_ce),    32'd0);
        check_val("rst_ready", 32'(o_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_val("rst_rel_ready", 32'(o_ready), 32'd1);
        stray = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (o_valid) stray = 1'b1;
            step();
        end
        check_val("rst_no_output", 32'(stray), 32'd0);
        $display("lat=%0d %-12s reset pulsed in GY", cur_lat, "reset");
        run_window({8'd10, 64'h0}, 10, 10, 20, 0, 1'b0, "post_rst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        valid    = 1'b0;
        ready_in = 1'b0;
        window   = 72'd0;
        sel      = 1'b0;
        cur_lat  = 1;
        #1;
        check_val("init_ready", 32'(o_ready), 32'd0);
        check_val("init_valid", 32'(o_valid), 32'd0);
        check_val("init_ce",    32'(o_ce),    32'd0);
        check_val("init_gx",    32'(o_gx),    32'd0);
        check_val("init_mag",   32'(o_mag),   32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check_val("init_rel_ready", 32'(o_ready), 32'd1);
        run_suite();
        sel     = 1'b1;
        cur_lat = 4;
        step();
        run_suite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_mac_seq.md
SOBEL_MAC_SEQ -- requirements
Module: sobel_mac_seq

Interface
REQ-001 SHALL have parameter MAC_LAT, default 1, legal 1..4: cycles from a term on mac_a_o/mac_b_o to its accumulated sum on mac_acc_i.
REQ-002 SHALL have port clk_i, input, 1: single clock, all state rising-edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1: window valid.
REQ-005 SHALL have port ready_o, output, 1: window accepted when valid_i & ready_o.
REQ-006 SHALL have port window_i, input, 72: 3x3 unsigned 8-bit pixels p0..p8, row-major, p0 = bits 7:0.
REQ-007 SHALL have port mac_a_o, output, 16: pixel term, zero-extended; MAC A-side unsigned.
REQ-008 SHALL have port mac_b_o, output, 16: coefficient, two's-complement sign-extended; MAC B-side signed.
REQ-009 SHALL have port mac_ce_o, output, 1: MAC clock enable.
REQ-010 SHALL have port mac_first_o, output, 1: accumulator loads the product instead of adding it.
REQ-011 SHALL have port mac_acc_i, input, 32: MAC accumulator output.
REQ-012 SHALL have port valid_o, output, 1: result valid.
REQ-013 SHALL have port ready_i, input, 1: result consumed when valid_o & ready_i.
REQ-014 SHALL have ports gx_o and gy_o, output, 11 each: signed gradients.
REQ-015 SHALL have port mag_o, output, 8: min(|gx|+|gy|, 255).

Function
REQ-016 SHALL implement the FSM states IDLE, GX, GY, DRAIN and OUT.
- IDLE -> GX on accept.
- GX -> GY after 6 terms.
- GY -> DRAIN after 6 terms.
- DRAIN -> OUT after MAC_LAT cycles.
- OUT -> IDLE on output handshake.
REQ-017 SHALL drive ready_o high only in IDLE and SHALL register window_i on accept.
REQ-018 SHALL issue one term per cycle, term k (0..11) in cycle k+1 after the accept edge.
REQ-019 SHALL use the GX term order (p0,-1) (p2,+1) (p3,-2) (p5,+2) (p6,-1) (p8,+1).
REQ-020 SHALL use the GY term order (p0,-1) (p1,-2) (p2,-1) (p6,+1) (p7,+2) (p8,+1).
REQ-021 SHALL assert mac_first_o only on term 0 and term 6.
REQ-022 SHALL hold mac_ce_o high in GX, GY and DRAIN, and low otherwise.
REQ-023 SHALL drive mac_a_o and mac_b_o to 0 outside GX/GY.
REQ-024 SHALL capture gx from mac_acc_i[10:0] at the end of cycle 6+MAC_LAT after accept.
REQ-025 SHALL capture gy from mac_acc_i[10:0] at the end of cycle 12+MAC_LAT after accept.
REQ-026 SHALL ignore mac_acc_i[31:11]; the legal gradient range is -1020..+1020.
REQ-027 SHALL register mag_o from the captured gx/gy: |gx|+|gy| at 12 bits unsigned, saturated to 255.
REQ-028 SHALL assert valid_o in cycle 13+MAC_LAT after accept, and SHALL assert it only in OUT.
REQ-029 SHALL hold gx_o, gy_o and mag_o stable while valid_o & !ready_i.
REQ-030 SHALL NOT accept a new window in the cycle of the output handshake; the next accept is earliest one cycle later, in IDLE.
REQ-031 SHALL NOT sample valid_i outside IDLE, which gives no overlap between windows.
REQ-032 SHALL NOT let a change of window_i after accept affect the result in progress.

Reset
REQ-033 SHALL, on rst_ni low at any time, asynchronously force the state to IDLE.
REQ-034 SHALL, on rst_ni low, force all outputs to 0 except ready_o.
REQ-035 SHALL drive ready_o to 0 while rst_ni is low and to 1 from the first cycle after release.
REQ-036 SHALL abandon any transaction in progress at reset with no partial output; the first window after release SHALL complete normally, starting with mac_first_o.

Verification
REQ-037 SHALL cover a flat field:
- Stimulus: all pixels 0x80.
- Response: gx=0, gy=0, mag=0, valid_o exactly 13+MAC_LAT cycles after accept.
REQ-038 SHALL cover a vertical edge:
- Stimulus: p2=p5=p8=255, rest 0.
- Response: gx=+1020, gy=0, mag=255 (saturated).
REQ-039 SHALL cover a horizontal edge:
- Stimulus: p0=p1=p2=255, rest 0.
- Response: gx=0, gy=-1020, mag=255.
REQ-040 SHALL cover a single corner pixel:
- Stimulus: p8=10, rest 0.
- Response: gx=+10, gy=+10, mag=20.
- Check: mac_first_o high only on terms 0 and 6.
REQ-041 SHALL cover backpressure:
- Stimulus: ready_i low for 5 cycles during OUT while valid_i stays high.
- Response: outputs stable, ready_o low, second window accepted one cycle after the handshake.
REQ-042 SHALL cover reset mid-operation:
- Stimulus: rst_ni pulsed low during GY.
- Response: valid_o=0 and the MAC outputs go to 0 immediately, with no output for the dropped window; the next window (p8=10) yields gx=10, gy=10.
- Run the suite at MAC_LAT=1 and MAC_LAT=4.
